// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: valid/ready byte intake into a small FIFO,
// serialised LSB-first with back-to-back frames while the FIFO holds data.
module uart_tx_fifo #(
  parameter int unsigned DELAY_FRAMES = 260,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic                         uart_tx,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = (DELAY_FRAMES > 1) ? $clog2(DELAY_FRAMES) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_state;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shreg;
  logic             r_tx;
  logic             r_busy;

  logic             w_push;
  logic             w_pop;
  logic             w_ready;
  logic             w_last;
  logic [1:0]       w_state_nx;
  logic [BIT_W-1:0] w_bit_cnt_nx;
  logic [2:0]       w_bit_idx_nx;
  logic [7:0]       w_shreg_nx;
  logic             w_tx_nx;
  logic [CNT_W-1:0] w_count_nx;
  logic             w_busy_nx;

  assign w_ready    = (r_count != CNT_W'(FIFO_DEPTH));
  assign w_push     = tx_valid && w_ready;
  assign w_last     = (r_bit_cnt == BIT_W'(DELAY_FRAMES - 1));
  assign tx_ready   = w_ready;
  assign uart_tx    = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;

  // Storage is not reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  // Next-state, serialiser and pop decision.
  always_comb begin
    w_state_nx   = r_state;
    w_bit_cnt_nx = r_bit_cnt;
    w_bit_idx_nx = r_bit_idx;
    w_shreg_nx   = r_shreg;
    w_tx_nx      = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nx = 1'b1;
        if (r_count != '0) begin
          w_pop        = 1'b1;
          w_shreg_nx   = r_mem[r_rd_ptr];
          w_bit_cnt_nx = '0;
          w_tx_nx      = 1'b0;
          w_state_nx   = S_START;
        end
      end
      S_START: begin
        if (w_last) begin
          w_bit_cnt_nx = '0;
          w_bit_idx_nx = 3'd0;
          w_tx_nx      = r_shreg[0];
          w_state_nx   = S_DATA;
        end else begin
          w_bit_cnt_nx = r_bit_cnt + BIT_W'(1);
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_bit_cnt_nx = '0;
          if (r_bit_idx == 3'd7) begin
            w_tx_nx    = 1'b1;
            w_state_nx = S_STOP;
          end else begin
            w_bit_idx_nx = r_bit_idx + 3'd1;
            w_tx_nx      = r_shreg[r_bit_idx + 3'd1];
          end
        end else begin
          w_bit_cnt_nx = r_bit_cnt + BIT_W'(1);
        end
      end
      S_STOP: begin
        if (w_last) begin
          w_bit_cnt_nx = '0;
          if (r_count != '0) begin
            w_pop      = 1'b1;
            w_shreg_nx = r_mem[r_rd_ptr];
            w_tx_nx    = 1'b0;
            w_state_nx = S_START;
          end else begin
            w_tx_nx    = 1'b1;
            w_state_nx = S_IDLE;
          end
        end else begin
          w_bit_cnt_nx = r_bit_cnt + BIT_W'(1);
        end
      end
      default: begin
        w_tx_nx      = 1'b1;
        w_bit_cnt_nx = '0;
        w_bit_idx_nx = 3'd0;
        w_state_nx   = S_IDLE;
      end
    endcase

    case ({w_push, w_pop})
      2'b10:   w_count_nx = r_count + CNT_W'(1);
      2'b01:   w_count_nx = r_count - CNT_W'(1);
      default: w_count_nx = r_count;
    endcase
    w_busy_nx = (w_state_nx != S_IDLE) || (w_count_nx != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shreg   <= 8'h00;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count   <= w_count_nx;
      r_state   <= w_state_nx;
      r_bit_cnt <= w_bit_cnt_nx;
      r_bit_idx <= w_bit_idx_nx;
      r_shreg   <= w_shreg_nx;
      r_tx      <= w_tx_nx;
      r_busy    <= w_busy_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: cycle-exact frame tables, a line decoder fed by a
// byte scoreboard, plus streaming, overflow, reset and push/pop corner cases.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data4, data260;
  logic       valid4, valid260;
  logic       ready4, ready260;
  logic       line4, line260;
  logic       busy4, busy260;
  logic [3:0] count4, count260;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] sb [$];

  uart_tx_fifo #(.DELAY_FRAMES(4), .FIFO_DEPTH(8)) dut4 (
    .clk(clk), .reset(reset), .tx_data(data4), .tx_valid(valid4),
    .tx_ready(ready4), .uart_tx(line4), .busy(busy4), .fifo_count(count4));

  uart_tx_fifo dut260 (
    .clk(clk), .reset(reset), .tx_data(data260), .tx_valid(valid260),
    .tx_ready(ready260), .uart_tx(line260), .busy(busy260), .fifo_count(count260));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line decoder for the DELAY_FRAMES=4 instance; pops the scoreboard per frame.
  int         cyc_n = 0;
  bit         mon_active = 0;
  int         mon_cyc = 0;
  logic       mon_bit;
  logic [7:0] mon_byte;
  bit         mon_bad;
  int         mon_frames = 0;
  int         mon_end = 0;
  bit         stream_mark = 0;
  int         mon_first_start = 0;

  always @(negedge clk) begin
    int k, j;
    logic [7:0] e;
    cyc_n++;
    if (reset) begin
      mon_active = 0;
    end else if (!mon_active) begin
      if (line4 == 1'b0) begin
        mon_active = 1; mon_cyc = 0; mon_bit = 1'b0; mon_byte = 8'h00; mon_bad = 0;
        if (stream_mark) begin mon_first_start = cyc_n; stream_mark = 0; end
      end
    end else begin
      mon_cyc++;
      k = mon_cyc / 4;
      j = mon_cyc % 4;
      if (j == 0) mon_bit = line4;
      else if (line4 !== mon_bit) mon_bad = 1;
      if (j == 0 && k >= 1 && k <= 8) mon_byte[k-1] = line4;
      if (mon_cyc == 39) begin
        check("mon_stop_bit", 32'(mon_bit), 32'd1);
        check("mon_bit_stable", 32'(mon_bad), 32'd0);
        if (sb.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL mon_unexpected_frame: got %0h expected none", mon_byte);
        end else begin
          e = sb.pop_front();
          check("mon_byte", 32'(mon_byte), 32'(e));
        end
        mon_active = 0;
        mon_end = cyc_n;
        mon_frames++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Offer one byte for one edge; called #1 after an edge.
  task automatic send(input bit big, input logic [7:0] b);
    bit acc;
    if (big) begin data260 = b; valid260 = 1'b1; acc = ready260; end
    else     begin data4   = b; valid4   = 1'b1; acc = ready4;   end
    @(posedge clk);
    if (acc && !big) sb.push_back(b);
    #1;
    valid4 = 1'b0; valid260 = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || mon_active) && n < budget) begin tick(); n++; end
    check("drain_timeout", 32'(n < budget), 32'd1);
  endtask

  // Send one byte and compare the line cycle by cycle against the expected frame.
  task automatic frame_check(input bit big, input logic [7:0] b, input logic [9:0] fr,
                             input string nm);
    int D, mism;
    D = big ? 260 : 4;
    send(big, b);
    check({nm, "_count_after_write"}, 32'(big ? count260 : count4), 32'd1);
    check({nm, "_busy_after_write"}, 32'(big ? busy260 : busy4), 32'd1);
    for (int k = 0; k < 10; k++) begin
      mism = 0;
      for (int j = 0; j < D; j++) begin
        tick();
        if ((big ? line260 : line4) !== fr[k]) mism++;
        if (k == 0 && j == 0)
          check({nm, "_count_after_pop"}, 32'(big ? count260 : count4), 32'd0);
        if (k == 9 && j == D - 1)
          check({nm, "_busy_last_stop"}, 32'(big ? busy260 : busy4), 32'd1);
      end
      check($sformatf("%s_bit%0d_mismatched_cycles", nm, k), 32'(mism), 32'd0);
    end
    tick();
    check({nm, "_busy_fall"}, 32'(big ? busy260 : busy4), 32'd0);
    check({nm, "_line_idle"}, 32'(big ? line260 : line4), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  vecs [5];
    string msg;
    int    i, nacc, cycles, f0;
    bit    acc;

    vecs[0] = '{8'h4C, 10'b1010011000};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};
    vecs[4] = '{8'h81, 10'b1100000010};

    reset = 1'b1; data4 = 8'h00; valid4 = 1'b0; data260 = 8'h00; valid260 = 1'b0;
    repeat (3) tick();
    check("rst_line", 32'(line4), 32'd1);
    check("rst_ready", 32'(ready4), 32'd1);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_count", 32'(count4), 32'd0);
    check("rst_line260", 32'(line260), 32'd1);
    #2 reset = 1'b0;
    @(posedge clk); #1;
    repeat (3) tick();
    check("idle_no_frame", 32'(line4), 32'd1);

    for (int v = 0; v < 5; v++)
      frame_check(1'b0, vecs[v].data, vecs[v].frame, $sformatf("vec%0d", v));
    repeat (2) tick();
    check("table_frames", 32'(mon_frames), 32'd5);

    // Streaming with tx_valid held, including a 3-cycle overflow attempt when full.
    msg = "Lushay Labs ";
    f0 = mon_frames;
    stream_mark = 1;
    i = 0; nacc = 0; cycles = 0;
    valid4 = 1'b1;
    while (i < 12 && cycles < 2000) begin
      data4 = msg[i];
      acc = ready4;
      @(posedge clk);
      cycles++;
      if (acc) begin sb.push_back(msg[i]); i++; nacc++; end
      #1;
      if (acc && nacc == 9) begin
        check("stream_full_count", 32'(count4), 32'd8);
        check("stream_full_ready", 32'(ready4), 32'd0);
        data4 = 8'hFF;
        for (int r = 0; r < 3; r++) begin
          tick();
          cycles++;
          check("overflow_count", 32'(count4), 32'd8);
        end
      end
    end
    valid4 = 1'b0;
    check("stream_all_accepted", 32'(i), 32'd12);
    wait_drain(1000);
    check("stream_frames", 32'(mon_frames - f0), 32'd12);
    check("stream_span", 32'(mon_end - mon_first_start + 1), 32'd480);
    repeat (3) tick();

    // Reset during DATA bit 3.
    send(1'b0, 8'h3C);
    repeat (18) tick();
    #2 reset = 1'b1;
    #1;
    check("midrst_line", 32'(line4), 32'd1);
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_count", 32'(count4), 32'd0);
    @(posedge clk); #1;
    repeat (2) tick();
    #2 reset = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    repeat (10) tick();
    check("postrst_busy", 32'(busy4), 32'd0);
    check("postrst_line", 32'(line4), 32'd1);
    f0 = mon_frames;
    send(1'b0, 8'hA5);
    repeat (45) tick();
    check("postrst_frames", 32'(mon_frames - f0), 32'd1);
    check("postrst_sb_empty", 32'(sb.size()), 32'd0);

    // Push lands on the STOP->START pop edge with count 1.
    f0 = mon_frames;
    send(1'b0, 8'h12);
    repeat (9) tick();
    send(1'b0, 8'h34);
    repeat (30) tick();
    check("pp_count_before", 32'(count4), 32'd1);
    check("pp_line_stop", 32'(line4), 32'd1);
    send(1'b0, 8'h56);
    check("pp_count_after", 32'(count4), 32'd1);
    check("pp_start_bit", 32'(line4), 32'd0);
    wait_drain(500);
    check("pp_frames", 32'(mon_frames - f0), 32'd3);

    // Default rate instance.
    frame_check(1'b1, 8'h55, 10'b1010101010, "rate260");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
